fp_soc_key_edge_pio: RTL and testbench



---
 rtl/fp_soc_key_edge_pio.sv | 118 +++++++++++
 tb/tb_fp_soc_key_edge_pio.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_soc_key_edge_pio.sv
// Avalon-MM input PIO for pushbuttons/switches: synchroniser, per-bit debouncer,
// data register, edge capture (RW1C) and maskable level interrupt.
module fp_soc_key_edge_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] IN_RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_c;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] edge_c;
    logic [WIDTH-1:0] clr_c;
    logic             wr_c;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry register content.
    assign unused_wdata = ^writedata;

    // Metastability shift chain per bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RESET_VALUE;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_c = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) deb_q <= IN_RESET_VALUE;
                else          deb_q <= sync_c;
            end
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0] cnt_q [WIDTH];

            // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatch.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb_q <= IN_RESET_VALUE;
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync_c[i] == deb_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            deb_q[i] <= sync_c[i];
                            cnt_q[i] <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    assign wr_c  = chipselect && !write_n;
    assign clr_c = (wr_c && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Edge selection on the debounced level.
    always_comb begin
        rise_c = deb_q & ~deb_d_q;
        fall_c = ~deb_q & deb_d_q;
        case (EDGE_MODE)
            0:       edge_c = rise_c;
            1:       edge_c = fall_c;
            default: edge_c = rise_c | fall_c;
        endcase
    end

    // Register file, interrupt and read-data pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d_q   <= IN_RESET_VALUE;
            edgecap_q <= '0;
            irqmask_q <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
        end else begin
            deb_d_q   <= deb_q;
            edgecap_q <= edge_c | (edgecap_q & ~clr_c);
            if (wr_c && address == 2'd2) irqmask_q <= writedata[WIDTH-1:0];
            irq <= |(edgecap_q & irqmask_q);
            case (address)
                2'd0:    readdata <= 32'(deb_q);
                2'd2:    readdata <= 32'(irqmask_q);
                2'd3:    readdata <= 32'(edgecap_q);
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_soc_key_edge_pio.sv
// Bench for fp_soc_key_edge_pio: rising-only and any-edge instances against a
// run-length behavioural model plus directed constant expectations.
module tb_fp_soc_key_edge_pio;

    localparam int unsigned W = 4;
    localparam int unsigned S = 2;
    localparam int unsigned D = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rdata0, rdata2;
    logic          irq0, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_soc_key_edge_pio #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata0), .irq(irq0));

    fp_soc_key_edge_pio #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata2), .irq(irq2));

    // Behavioural model: input delayed through a queue, level accepted after D
    // consecutive disagreeing cycles, sticky captures, registered read and irq.
    logic [W-1:0] m_pipe [$];
    logic [W-1:0] m_deb, m_deb_prev, m_mask, m_ec0, m_ec2;
    logic [31:0]  m_rd0, m_rd2;
    logic         m_irq0, m_irq2;
    int           m_run [W];

    always @(posedge clk or negedge reset_n) begin : model
        logic [W-1:0] m_sync, m_rise, m_fall, m_clr;
        logic         m_wr;
        if (!reset_n) begin
            m_pipe = {};
            for (int s = 0; s < S; s++) m_pipe.push_back('0);
            m_deb = '0; m_deb_prev = '0; m_mask = '0; m_ec0 = '0; m_ec2 = '0;
            m_rd0 = '0; m_rd2 = '0; m_irq0 = 1'b0; m_irq2 = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_sync = m_pipe[0];
            m_rise = m_deb & ~m_deb_prev;
            m_fall = ~m_deb & m_deb_prev;
            m_wr   = chipselect && !write_n;
            m_clr  = (m_wr && address == 2'd3) ? writedata[W-1:0] : '0;
            case (address)
                2'd0:    begin m_rd0 = 32'(m_deb);  m_rd2 = 32'(m_deb);  end
                2'd2:    begin m_rd0 = 32'(m_mask); m_rd2 = 32'(m_mask); end
                2'd3:    begin m_rd0 = 32'(m_ec0);  m_rd2 = 32'(m_ec2);  end
                default: begin m_rd0 = '0;          m_rd2 = '0;          end
            endcase
            m_irq0 = |(m_ec0 & m_mask);
            m_irq2 = |(m_ec2 & m_mask);
            m_ec0  = m_rise | (m_ec0 & ~m_clr);
            m_ec2  = m_rise | m_fall | (m_ec2 & ~m_clr);
            if (m_wr && address == 2'd2) m_mask = writedata[W-1:0];
            m_deb_prev = m_deb;
            for (int i = 0; i < W; i++) begin
                if (m_sync[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = m_sync[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            void'(m_pipe.pop_front());
            m_pipe.push_back(in_port);
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        @(negedge clk);
        address = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] addrs [4];
        addrs = '{2'd0, 2'd1, 2'd2, 2'd3};
        reset_n = 1'b0; in_port = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        foreach (addrs[k]) begin
            bus_rd(addrs[k]);
            checks++;
            if (rdata0 !== 32'h0 || rdata2 !== 32'h0)
                $display("FAIL reset_read addr%0d got %h/%h exp 0", addrs[k], rdata0, rdata2);
        end
        checks++;
        if (irq0 !== 1'b0 || irq2 !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b/%b exp 0", irq0, irq2);
        end
    endtask

    task automatic test_debounce_timing();
        logic exp;
        @(negedge clk);
        address = 2'd0; in_port[0] = 1'b1;
        for (int k = 1; k <= int'(S + D + 3); k++) begin
            @(negedge clk);
            exp = (k >= int'(S + D + 1));
            checks++;
            if (rdata0[0] !== exp || rdata2[0] !== exp || rdata0 !== m_rd0) begin
                errors++;
                $display("FAIL deb_timing cycle%0d got %h/%h exp bit0=%b model %h", k, rdata0, rdata2, exp, m_rd0);
            end
        end
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h1 || rdata2 !== 32'h1 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
            errors++; $display("FAIL rise_capture got %h/%h irq %b/%b exp 1 irq 0", rdata0, rdata2, irq0, irq2);
        end
    endtask

    task automatic test_irq_mask();
        bus_wr(2'd2, 32'h1);
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b1 || irq2 !== 1'b1) begin
            errors++; $display("FAIL irq_on_mask got %b/%b exp 1", irq0, irq2);
        end
        bus_wr(2'd3, 32'h1);
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b0 || irq2 !== 1'b0) begin
            errors++; $display("FAIL irq_on_clear got %b/%b exp 0", irq0, irq2);
        end
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++; $display("FAIL w1c_clear got %h/%h exp 0", rdata0, rdata2);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk); in_port[1] = 1'b1;
        repeat (3) @(negedge clk);
        in_port[1] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(2'd0);
        checks++;
        if (rdata0[1] !== 1'b0 || rdata0 !== m_rd0) begin
            errors++; $display("FAIL glitch_data got %h exp bit1=0 model %h", rdata0, m_rd0);
        end
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++; $display("FAIL glitch_capture got %h/%h exp 0", rdata0, rdata2);
        end
        @(negedge clk); in_port[1] = 1'b1;
        repeat (4) @(negedge clk);
        in_port[1] = 1'b0;
        repeat (12) @(negedge clk);
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h2 || rdata2 !== 32'h2) begin
            errors++; $display("FAIL hold4_capture got %h/%h exp 2", rdata0, rdata2);
        end
        bus_wr(2'd3, 32'hF);
    endtask

    task automatic test_set_wins();
        @(negedge clk); in_port[2] = 1'b1;
        repeat (S + D - 1) @(negedge clk);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h4 || rdata2 !== 32'h4) begin
            errors++; $display("FAIL set_wins got %h/%h exp 4", rdata0, rdata2);
        end
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++; $display("FAIL clear_after_set got %h/%h exp 0", rdata0, rdata2);
        end
    endtask

    task automatic test_any_edge();
        @(negedge clk); in_port = '0;
        repeat (12) @(negedge clk);
        bus_wr(2'd3, 32'hF);
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++; $display("FAIL any_edge_clean got %h/%h exp 0", rdata0, rdata2);
        end
        in_port[3] = 1'b1;
        repeat (S + D + 4) @(negedge clk);
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h8 || rdata2 !== 32'h8) begin
            errors++; $display("FAIL any_edge_rise got %h/%h exp 8/8", rdata0, rdata2);
        end
        bus_wr(2'd3, 32'hF);
        in_port[3] = 1'b0;
        repeat (S + D + 4) @(negedge clk);
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h0 || rdata2 !== 32'h8) begin
            errors++; $display("FAIL any_edge_fall got %h/%h exp 0/8", rdata0, rdata2);
        end
        bus_wr(2'd3, 32'hF);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (rdata0 !== m_rd0 || irq0 !== m_irq0) begin
                errors++; $display("FAIL rand_mode0 cycle%0d got %h/%b exp %h/%b", c, rdata0, irq0, m_rd0, m_irq0);
            end
            checks++;
            if (rdata2 !== m_rd2 || irq2 !== m_irq2) begin
                errors++; $display("FAIL rand_mode2 cycle%0d got %h/%b exp %h/%b", c, rdata2, irq2, m_rd2, m_irq2);
            end
            chipselect = 1'b0; write_n = 1'b1; writedata = '0;
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                write_n = 1'b0;
            end
        end
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); in_port = '0;
        repeat (12) @(negedge clk);
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd2, 32'hF);
        in_port = 4'b0110;
        repeat (S + D + 4) @(negedge clk);
        checks++;
        if (irq0 !== 1'b1 || irq2 !== 1'b1) begin
            errors++; $display("FAIL pre_reset_irq got %b/%b exp 1", irq0, irq2);
        end
        address = 2'd2; in_port = '0;
        repeat (S + 2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rdata0 !== 32'h0 || rdata2 !== 32'h0 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
            errors++; $display("FAIL async_reset got %h/%h irq %b/%b exp 0", rdata0, rdata2, irq0, irq2);
        end
        in_port = 4'b0110;
        @(negedge clk); reset_n = 1'b1;
        repeat (S + D + 3) @(negedge clk);
        bus_rd(2'd0);
        checks++;
        if (rdata0 !== 32'h6 || rdata2 !== 32'h6) begin
            errors++; $display("FAIL post_reset_data got %h/%h exp 6", rdata0, rdata2);
        end
        bus_rd(2'd3);
        checks++;
        if (rdata0 !== 32'h6 || rdata2 !== 32'h6 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
            errors++; $display("FAIL post_reset_capture got %h/%h irq %b/%b exp 6 irq 0", rdata0, rdata2, irq0, irq2);
        end
    endtask

    initial begin
        test_reset();
        test_debounce_timing();
        test_irq_mask();
        test_glitch();
        test_set_wins();
        test_any_edge();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
